// File: rtl/hub75_frame_reader.sv
// HUB75 read side: walks the framebuffer one pixel-pair word per column and
// drives the panel with binary-coded modulation over BPC bit planes.
`timescale 1ns/1ps
module hub75_frame_reader #(
  parameter int WIDTH      = 96,
  parameter int HEIGHT     = 48,
  parameter int BPC        = 4,
  parameter int CHAINED    = 1,
  parameter int BASE_DELAY = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [11:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_data,
  output logic [2:0]  rgb0,
  output logic [2:0]  rgb1,
  output logic [4:0]  row_addr,
  output logic        panel_clk,
  output logic        latch,
  output logic        oe_n,
  output logic        frame_done
);

  localparam int COLS    = CHAINED * WIDTH;
  localparam int ROWS    = HEIGHT / 2;
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PLANE_W = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int DLY_MAX = BASE_DELAY << (BPC - 1);
  localparam int DLY_W   = $clog2(DLY_MAX + 1);

  localparam logic [11:0]      COLS12 = 12'(COLS);
  localparam logic [DLY_W-1:0] BASE_D = DLY_W'(BASE_DELAY);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SETUP, S_CLOCK, S_LATCH, S_DISPLAY, S_BLANK
  } state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [PLANE_W-1:0] plane_q;
  logic [DLY_W-1:0]   dly_q;

  logic col_last, row_last, plane_last;
  assign col_last   = (col_q == COL_W'(COLS - 1));
  assign row_last   = (row_q == ROW_W'(ROWS - 1));
  assign plane_last = (plane_q == PLANE_W'(BPC - 1));

  assign mem_addr = 12'(row_q) * COLS12 + 12'(col_q);

  // Nibbles of the upper (bits 11:0) and lower (bits 23:12) pixel.
  logic [3:0] r0, g0, b0, r1, g1, b1;
  assign {r0, g0, b0} = mem_data[11:0];
  assign {r1, g1, b1} = mem_data[23:12];

  logic unused_bits;
  assign unused_bits = ^mem_data[31:24];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    mem_re     = 1'b0;
    panel_clk  = 1'b0;
    latch      = 1'b0;
    oe_n       = 1'b1;
    frame_done = 1'b0;
    unique case (state_q)
      S_IDLE:    if (enable) state_d = S_FETCH;
      S_FETCH: begin
        mem_re  = 1'b1;
        state_d = S_SETUP;
      end
      S_SETUP:   state_d = S_CLOCK;
      S_CLOCK: begin
        panel_clk = 1'b1;
        state_d   = col_last ? S_LATCH : S_FETCH;
      end
      S_LATCH: begin
        latch   = 1'b1;
        state_d = S_DISPLAY;
      end
      S_DISPLAY: begin
        oe_n = 1'b0;
        if (dly_q == '0) state_d = S_BLANK;
      end
      S_BLANK: begin
        frame_done = plane_last && row_last;
        state_d    = enable ? S_FETCH : S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      plane_q  <= '0;
      dly_q    <= '0;
      rgb0     <= '0;
      rgb1     <= '0;
      row_addr <= '0;
    end else begin
      unique case (state_q)
        S_SETUP: begin
          rgb0 <= {r0[plane_q], g0[plane_q], b0[plane_q]};
          rgb1 <= {r1[plane_q], g1[plane_q], b1[plane_q]};
        end
        S_CLOCK: begin
          if (col_last) begin
            col_q    <= '0;
            // Updated on entry to LATCH so the row changes while oe_n is high.
            row_addr <= 5'(row_q);
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        S_LATCH:   dly_q <= (BASE_D << plane_q) - DLY_W'(1);
        S_DISPLAY: if (dly_q != '0) dly_q <= dly_q - 1'b1;
        S_BLANK: begin
          if (plane_last) begin
            plane_q <= '0;
            row_q   <= row_last ? '0 : row_q + 1'b1;
          end else begin
            plane_q <= plane_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_frame_reader.sv
// Scoreboard bench for hub75_frame_reader: a frame-level reference model queues
// expected fetches, pixel bits, latches and display windows; a monitor compares.
`timescale 1ns/1ps
module tb_hub75_frame_reader;

  localparam int WIDTH      = 96;
  localparam int HEIGHT     = 48;
  localparam int BPC        = 4;
  localparam int CHAINED    = 1;
  localparam int BASE_DELAY = 4;
  localparam int COLS       = CHAINED * WIDTH;
  localparam int ROWS       = HEIGHT / 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [11:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_data = '0;
  logic [2:0]  rgb0, rgb1;
  logic [4:0]  row_addr;
  logic        panel_clk, latch, oe_n, frame_done;

  hub75_frame_reader #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BPC(BPC),
    .CHAINED(CHAINED), .BASE_DELAY(BASE_DELAY)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_data(mem_data),
    .rgb0(rgb0), .rgb1(rgb1), .row_addr(row_addr),
    .panel_clk(panel_clk), .latch(latch), .oe_n(oe_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Framebuffer port model: data valid the cycle after the read enable.
  logic [31:0] mem [4096];
  always @(posedge clk) if (mem_re) mem_data <= mem[mem_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Expected-event queues filled by the reference model.
  logic [11:0] q_addr[$];
  logic [5:0]  q_rgb[$];
  logic [4:0]  q_row[$];
  int          q_len[$];
  logic        q_fd[$];

  int m_row = 0;
  int m_plane = 0;

  // One plane of one scan row, from the panel's rules rather than the FSM.
  task automatic model_next_plane();
    logic [31:0] w;
    int p;
    p = m_plane;
    for (int c = 0; c < COLS; c++) begin
      w = mem[m_row * COLS + c];
      q_addr.push_back(12'(m_row * COLS + c));
      q_rgb.push_back({w[8+p], w[4+p], w[p], w[20+p], w[16+p], w[12+p]});
    end
    q_row.push_back(5'(m_row));
    q_len.push_back(BASE_DELAY << p);
    q_fd.push_back((m_row == ROWS - 1) && (p == BPC - 1));
    m_plane++;
    if (m_plane == BPC) begin
      m_plane = 0;
      m_row = (m_row + 1) % ROWS;
    end
  endtask

  logic mon_en = 1'b0;
  int   clk_cnt = 0;
  int   low_cnt = 0;
  logic prev_latch = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_re) begin
        if (q_addr.size() == 0) fail("unexpected_fetch");
        else check("mem_addr", mem_addr, q_addr.pop_front());
      end
      if (panel_clk) begin
        logic [5:0] e;
        clk_cnt++;
        if (q_rgb.size() == 0) fail("unexpected_shift");
        else begin
          e = q_rgb.pop_front();
          check("rgb0", rgb0, e[5:3]);
          check("rgb1", rgb1, e[2:0]);
        end
      end
      if (latch) begin
        check("latch_oe_n", oe_n, 1);
        check("shift_count", clk_cnt, COLS);
        clk_cnt = 0;
        if (q_row.size() == 0) fail("unexpected_latch");
        else check("row_addr", row_addr, q_row.pop_front());
      end
      if (!oe_n) begin
        if (low_cnt == 0) check("latch_before_display", prev_latch, 1);
        low_cnt++;
      end else if (low_cnt != 0) begin
        if (q_len.size() == 0) fail("unexpected_display");
        else begin
          check("display_len", low_cnt, q_len.pop_front());
          check("frame_done", frame_done, q_fd.pop_front());
        end
        low_cnt = 0;
      end else if (frame_done) begin
        fail("stray_frame_done");
      end
      prev_latch = latch;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oe_n"}, oe_n, 1);
    check({tag, "_panel_clk"}, panel_clk, 0);
    check({tag, "_latch"}, latch, 0);
    check({tag, "_mem_re"}, mem_re, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_row_addr"}, row_addr, 0);
    check({tag, "_rgb"}, {rgb0, rgb1}, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int n_latch;
    int n_re;

    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[0] = 32'h00ABC5A3;

    rst = 1'b1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // Run a little, then hit reset in the middle of a CLOCK cycle.
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk); #1;
      if (panel_clk && mem_addr >= 12'd5) found = 1'b1;
    end
    check("reach_clock_state", found, 1);
    rst = 1'b1;
    #1 check_reset_outputs("mid_clock_reset");
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Full frame 0 plus all four planes of frame 1 row 0.
    for (int i = 0; i < ROWS * BPC + BPC; i++) model_next_plane();
    mon_en = 1'b1;
    @(posedge clk); #1 enable = 1'b1;

    n_latch = 0;
    for (int i = 0; i < 40000 && n_latch < ROWS * BPC + 1; i++) begin
      @(posedge clk); #1;
      if (latch) n_latch++;
    end
    check("latches_before_drop", n_latch, ROWS * BPC + 1);

    // Drop enable on column 10 of plane 1.
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_re && mem_addr == 12'd10) found = 1'b1;
    end
    check("col10_plane1_fetch", found, 1);
    enable = 1'b0;

    repeat (400) @(posedge clk);
    #1;
    n_re = 0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mem_re) n_re++;
      if (!oe_n) found = 1'b1;
    end
    check("idle_no_fetch", n_re, 0);
    check("idle_oe_n_high", found, 0);
    check("idle_pending_planes", q_len.size(), 2);

    // Resume: plane 2 starts at row base; stop after plane 3 starts.
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_re) found = 1'b1;
    end
    check("resume_fetch", found, 1);
    check("resume_addr", mem_addr, 0);
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(posedge clk); #1;
      if (latch) found = 1'b1;
    end
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_re) found = 1'b1;
    end
    check("plane3_start", found, 1);
    enable = 1'b0;

    for (int i = 0; i < 2000 && (q_len.size() != 0 || low_cnt != 0); i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    check("queues_drained", q_addr.size() + q_rgb.size() + q_row.size() + q_len.size(), 0);
    check("final_oe_n", oe_n, 1);
    check("final_mem_re", mem_re, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
